// File: rtl/request_unit.sv
// request_unit: fetch/execute/memory request sequencer that latches the instruction and owns the memory strobes.
// Optional performance counters are enabled with `define REQUEST_UNIT_PERF_EN.
module request_unit #(
    parameter int WORD_W = 32
`ifdef REQUEST_UNIT_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              dren_req,
    input  logic              dwen_req,
    input  logic              halt_req,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              pc_en,
`ifdef REQUEST_UNIT_PERF_EN
    output logic              halt,
    output logic [PERF_W-1:0] instr_count,
    output logic [PERF_W-1:0] stall_count
`else
    output logic              halt
`endif
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

    state_t r_state, w_next;
    logic   r_wr, w_wr_next;

    always_comb begin
        w_next    = r_state;
        w_wr_next = r_wr;
        unique case (r_state)
            FETCH:   w_next = ihit ? EXEC : FETCH;
            EXEC: begin
                w_next    = halt_req ? HALTED : (dwen_req | dren_req) ? MEM : FETCH;
                w_wr_next = dwen_req;
            end
            MEM:     w_next = dhit ? FETCH : MEM;
            default: w_next = HALTED;
        endcase
    end

    assign pc_en = (r_state == EXEC && !halt_req && !dwen_req && !dren_req) || (r_state == MEM && dhit);

    // Strobes are registered from the next state so they stay glitch-free.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= FETCH;
            r_wr        <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            imemREN     <= 1'b1;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            halt        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr    <= w_wr_next;
            imemREN <= w_next == FETCH;
            dmemREN <= w_next == MEM && !w_wr_next;
            dmemWEN <= w_next == MEM && w_wr_next;
            halt    <= w_next == HALTED;
            if (r_state == FETCH && ihit) begin
                instr       <= imemload;
                instr_valid <= 1'b1;
            end else if (pc_en) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef REQUEST_UNIT_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (pc_en)
                instr_count <= instr_count + 1'b1;
            if ((r_state == FETCH && !ihit) || (r_state == MEM && !dhit))
                stall_count <= stall_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: vector table, corner sequences and randomized run against a behavioural model.
module tb_request_unit;
    localparam int W = 32;
    typedef logic [W+5:0] obs_t;
    typedef struct {
        logic         ih, dh;
        logic [W-1:0] ld;
        logic         dr, dw, hr;
        obs_t         exp;
    } vec_t;

    logic         CLK = 1'b0, nRST = 1'b0;
    logic         ihit = 1'b0, dhit = 1'b0, dren_req = 1'b0, dwen_req = 1'b0, halt_req = 1'b0;
    logic [W-1:0] imemload = '0, instr;
    logic         instr_valid, imemREN, dmemREN, dmemWEN, pc_en, halt;
`ifdef REQUEST_UNIT_PERF_EN
    logic [31:0]  instr_count, stall_count;
`endif
    obs_t         obs;
    int           n_cmp = 0, n_bad = 0;

    localparam logic [W-1:0] A_OP = 32'h00221820, L_OP = 32'h8C410004;
    localparam logic [W-1:0] S_OP = 32'hAC410008, H_OP = 32'hFC000000;

    always #5 CLK = ~CLK;

    request_unit #(.WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .imemload(imemload),
        .dren_req(dren_req), .dwen_req(dwen_req), .halt_req(halt_req),
        .instr(instr), .instr_valid(instr_valid), .imemREN(imemREN),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc_en(pc_en),
`ifdef REQUEST_UNIT_PERF_EN
        .halt(halt), .instr_count(instr_count), .stall_count(stall_count)
`else
        .halt(halt)
`endif
    );

    assign obs = {instr, instr_valid, imemREN, dmemREN, dmemWEN, pc_en, halt};

    function automatic obs_t o(logic [W-1:0] ins, bit v, bit im, bit dr, bit dw, bit pc, bit h);
        return {ins, v, im, dr, dw, pc, h};
    endfunction

    function automatic vec_t mk(bit ih, bit dh, logic [W-1:0] ld, bit dr, bit dw, bit hr, obs_t e);
        vec_t r;
        r.ih = ih; r.dh = dh; r.ld = ld; r.dr = dr; r.dw = dw; r.hr = hr; r.exp = e;
        return r;
    endfunction

    task automatic check(string name, obs_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got {instr,v,iREN,dREN,dWEN,pc_en,halt}=%h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_in(bit ih, bit dh, logic [W-1:0] ld, bit dr, bit dw, bit hr);
        ihit = ih; dhit = dh; imemload = ld; dren_req = dr; dwen_req = dw; halt_req = hr;
    endtask

    // Called at a negedge: drive inputs, check mid-phase, advance one clock, return at the next negedge.
    task automatic cycle(string name, bit ih, bit dh, logic [W-1:0] ld, bit dr, bit dw, bit hr, obs_t exp);
        set_in(ih, dh, ld, dr, dw, hr);
        #1 check(name, exp);
        @(negedge CLK);
    endtask

    // Behavioural model: phase F/E/M/H plus latched word and counters.
    byte         m_ph;
    logic [W-1:0] m_instr;
    bit          m_v, m_wr;
    int unsigned m_ic, m_sc;

    function automatic bit m_pc();
        return (m_ph == "E" && !halt_req && !dwen_req && !dren_req) || (m_ph == "M" && dhit);
    endfunction

    function automatic obs_t m_out();
        return o(m_instr, m_v, m_ph == "F", m_ph == "M" && !m_wr, m_ph == "M" && m_wr, m_pc(), m_ph == "H");
    endfunction

    task automatic m_reset();
        m_ph = "F"; m_instr = '0; m_v = 0; m_wr = 0; m_ic = 0; m_sc = 0;
    endtask

    task automatic m_step();
        if (m_pc()) begin m_ic++; m_v = 0; end
        if ((m_ph == "F" && !ihit) || (m_ph == "M" && !dhit)) m_sc++;
        if (m_ph == "F" && ihit) begin
            m_instr = imemload; m_v = 1; m_ph = "E";
        end else if (m_ph == "E") begin
            m_wr = dwen_req;
            m_ph = halt_req ? "H" : (dwen_req || dren_req) ? "M" : "F";
        end else if (m_ph == "M" && dhit) begin
            m_ph = "F";
        end
    endtask

    // Called at a negedge; returns at a negedge with reset released and inputs idle.
    task automatic do_reset();
        set_in(0, 0, '0, 0, 0, 0);
        nRST = 1'b0;
        #1 check("reset", o('0, 0, 1, 0, 0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        m_reset();
    endtask

    vec_t tv[18];

    initial begin
        int halted;
        tv[0]  = mk(1, 0, A_OP, 0, 0, 0, o('0,   0, 1, 0, 0, 0, 0));
        tv[1]  = mk(0, 0, '0,   0, 0, 0, o(A_OP, 1, 0, 0, 0, 1, 0));
        tv[2]  = mk(0, 0, '0,   0, 0, 0, o(A_OP, 0, 1, 0, 0, 0, 0));
        tv[3]  = mk(1, 0, L_OP, 0, 0, 0, o(A_OP, 0, 1, 0, 0, 0, 0));
        tv[4]  = mk(0, 0, '0,   1, 0, 0, o(L_OP, 1, 0, 0, 0, 0, 0));
        tv[5]  = mk(1, 0, '0,   0, 0, 0, o(L_OP, 1, 0, 1, 0, 0, 0));
        tv[6]  = mk(0, 0, '0,   1, 1, 1, o(L_OP, 1, 0, 1, 0, 0, 0));
        tv[7]  = mk(0, 0, '0,   0, 0, 0, o(L_OP, 1, 0, 1, 0, 0, 0));
        tv[8]  = mk(0, 1, '0,   0, 0, 0, o(L_OP, 1, 0, 1, 0, 1, 0));
        tv[9]  = mk(0, 1, '0,   0, 0, 0, o(L_OP, 0, 1, 0, 0, 0, 0));
        tv[10] = mk(1, 0, S_OP, 0, 0, 0, o(L_OP, 0, 1, 0, 0, 0, 0));
        tv[11] = mk(0, 0, '0,   1, 1, 0, o(S_OP, 1, 0, 0, 0, 0, 0));
        tv[12] = mk(1, 0, '0,   1, 0, 1, o(S_OP, 1, 0, 0, 1, 0, 0));
        tv[13] = mk(0, 1, '0,   0, 0, 0, o(S_OP, 1, 0, 0, 1, 1, 0));
        tv[14] = mk(0, 0, '0,   0, 0, 0, o(S_OP, 0, 1, 0, 0, 0, 0));
        tv[15] = mk(1, 0, H_OP, 0, 0, 0, o(S_OP, 0, 1, 0, 0, 0, 0));
        tv[16] = mk(0, 0, '0,   0, 1, 1, o(H_OP, 1, 0, 0, 0, 0, 0));
        tv[17] = mk(1, 1, '0,   1, 1, 1, o(H_OP, 1, 0, 0, 0, 0, 1));

        @(negedge CLK);
        do_reset();
        for (int i = 0; i < 18; i++)
            cycle($sformatf("vec%0d", i), tv[i].ih, tv[i].dh, tv[i].ld, tv[i].dr, tv[i].dw, tv[i].hr, tv[i].exp);
        for (int i = 0; i < 100; i++)
            cycle("halt_sticky", 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  o(H_OP, 1, 0, 0, 0, 0, 1));

        // Reset dropped mid-MEM, between clock edges.
        do_reset();
        cycle("rst_fetch", 1, 0, S_OP, 0, 0, 0, o('0,   0, 1, 0, 0, 0, 0));
        cycle("rst_exec",  0, 0, '0,   0, 1, 0, o(S_OP, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, '0, 0, 0, 0);
        #1 check("rst_mem", o(S_OP, 1, 0, 0, 1, 0, 0));
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check("rst_async", o('0, 0, 1, 0, 0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        cycle("rst_after", 1, 0, A_OP, 0, 0, 0, o('0, 0, 1, 0, 0, 0, 0));
        cycle("rst_exec2", 0, 0, '0,   0, 0, 0, o(A_OP, 1, 0, 0, 0, 1, 0));

`ifdef REQUEST_UNIT_PERF_EN
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in(0, 0, '0, 0, 0, 0);
            repeat (2) @(negedge CLK);
            set_in(1, 0, k < 5 ? A_OP : H_OP, 0, 0, 0);
            @(negedge CLK);
            set_in(0, 0, '0, 0, 0, k == 5);
            @(negedge CLK);
        end
        set_in(0, 0, '0, 0, 0, 0);
        #1;
        check_val("perf_instr", instr_count, 5);
        check_val("perf_stall", stall_count, 12);
        repeat (20) @(negedge CLK);
        #1;
        check_val("perf_instr_frozen", instr_count, 5);
        check_val("perf_stall_frozen", stall_count, 12);
        @(negedge CLK);
`endif

        do_reset();
        halted = 0;
        for (int i = 0; i < 3000; i++) begin
            if (halted > 5) begin
                do_reset();
                halted = 0;
            end
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
            #1 check("rand", m_out());
`ifdef REQUEST_UNIT_PERF_EN
            check_val("rand_icnt", instr_count, m_ic);
            check_val("rand_scnt", stall_count, m_sc);
`endif
            @(posedge CLK);
            m_step();
            if (m_ph == "H") halted++;
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
